// File: rtl/pe_dc.sv
// Decoder-stage binary conv PE: XNOR/popcount over an unpool-masked window,
// thresholded against a folded batch-norm reference, one registered bit per output pixel.
module pe_dc #(
    parameter int D        = 4,
    parameter int FH       = 3,
    parameter int FW       = 3,
    parameter int POOL_H   = 2,
    parameter int POOL_W   = 2,
    parameter int STRIDE_H = 1,
    parameter int STRIDE_W = 1,
    localparam int IH           = (POOL_H - 1) * STRIDE_H + FH,
    localparam int IW           = (POOL_W - 1) * STRIDE_W + FW,
    localparam int IN_WIDTH     = IH * IW * D,
    localparam int PINDEX_WIDTH = IH * IW,
    localparam int OUT_WIDTH    = POOL_H * POOL_W,
    localparam int KW           = FH * FW * D,
    localparam int REF_WIDTH    = $clog2(KW + 1) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_in,
    input  logic [IN_WIDTH-1:0]         data_in,
    input  logic [KW-1:0]               weight_in,
    input  logic signed [REF_WIDTH-1:0] norm_ref,
    input  logic [PINDEX_WIDTH-1:0]     pindex,
    output logic                        valid_out,
    output logic [OUT_WIDTH-1:0]        data_out
);

    localparam logic signed [REF_WIDTH-1:0] ONE = REF_WIDTH'(1);

    // Empty (unpooled-away) positions contribute 0, otherwise +1 on XNOR match, -1 on mismatch.
    function automatic logic signed [REF_WIDTH-1:0] pixel_sum(
        input logic [IN_WIDTH-1:0]     win,
        input logic [KW-1:0]           wt,
        input logic [PINDEX_WIDTH-1:0] msk,
        input int                      pr,
        input int                      pc
    );
        logic signed [REF_WIDTH-1:0] acc;
        int r;
        int c;
        acc = '0;
        for (int fr = 0; fr < FH; fr++) begin
            for (int fc = 0; fc < FW; fc++) begin
                r = pr * STRIDE_H + fr;
                c = pc * STRIDE_W + fc;
                for (int d = 0; d < D; d++) begin
                    if (msk[r * IW + c]) begin
                        if (win[(r * IW + c) * D + d] == wt[(fr * FW + fc) * D + d])
                            acc = acc + ONE;
                        else
                            acc = acc - ONE;
                    end
                end
            end
        end
        return acc;
    endfunction

    logic [OUT_WIDTH-1:0] w_bits_p0;
    logic [OUT_WIDTH-1:0] r_data_p1;
    logic                 r_vld_p1;

    // ---- stage p0: combinational sum and threshold per output pixel ----
    always_comb begin
        w_bits_p0 = '0;
        for (int pr = 0; pr < POOL_H; pr++) begin
            for (int pc = 0; pc < POOL_W; pc++) begin
                w_bits_p0[pr * POOL_W + pc] =
                    (pixel_sum(data_in, weight_in, pindex, pr, pc) >= norm_ref);
            end
        end
    end

    // ---- stage p1: output registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_p1 <= '0;
            r_vld_p1  <= 1'b0;
        end else begin
            r_vld_p1 <= valid_in;
            if (valid_in)
                r_data_p1 <= w_bits_p0;
        end
    end

    assign valid_out = r_vld_p1;
    assign data_out  = r_data_p1;

endmodule

// File: tb/tb_pe_dc.sv
// Scoreboard bench for pe_dc: directed vectors with hand-computed results plus
// random vectors checked against an independent popcount model.
module tb_pe_dc;

    localparam int IN_WIDTH = 64;
    localparam int KW       = 36;
    localparam int PW       = 16;
    localparam int OW       = 4;
    localparam int RW       = 7;

    logic                 clk;
    logic                 rst;
    logic                 valid_in;
    logic [IN_WIDTH-1:0]  data_in;
    logic [KW-1:0]        weight_in;
    logic signed [RW-1:0] norm_ref;
    logic [PW-1:0]        pindex;
    logic                 valid_out;
    logic [OW-1:0]        data_out;

    int checks = 0;
    int errors = 0;
    logic [OW-1:0] exp_q[$];

    pe_dc dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .weight_in (weight_in),
        .norm_ref  (norm_ref),
        .pindex    (pindex),
        .valid_out (valid_out),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Model: S = 2*matches - unmasked_terms, iterated over the flat filter index.
    function automatic logic [OW-1:0] model(input logic [IN_WIDTH-1:0] dat,
                                            input logic [KW-1:0] w,
                                            input logic signed [RW-1:0] nref,
                                            input logic [PW-1:0] p);
        logic [OW-1:0] res;
        res = '0;
        for (int pr = 0; pr < 2; pr++) begin
            for (int pc = 0; pc < 2; pc++) begin
                int ones;
                int used;
                ones = 0;
                used = 0;
                for (int k = 0; k < KW; k++) begin
                    int fr, fc, d, pos;
                    fr  = k / 12;
                    fc  = (k / 4) % 3;
                    d   = k % 4;
                    pos = (pr + fr) * 4 + (pc + fc);
                    if (p[pos]) begin
                        used++;
                        if (dat[pos * 4 + d] == w[k]) ones++;
                    end
                end
                res[pr * 2 + pc] = ((2 * ones - used) >= int'(nref));
            end
        end
        return res;
    endfunction

    task automatic drive(input logic r, input logic v, input logic [IN_WIDTH-1:0] dat,
                         input logic [KW-1:0] w, input logic signed [RW-1:0] nref,
                         input logic [PW-1:0] p, input logic [OW-1:0] expv);
        @(negedge clk);
        rst       = r;
        valid_in  = v;
        data_in   = dat;
        weight_in = w;
        norm_ref  = nref;
        pindex    = p;
        if (v && !r) exp_q.push_back(expv);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, '0, '0, '0);
    endtask

    // Monitor: pops on valid_out, otherwise checks the reset value or the held output.
    initial begin
        logic          rst_s;
        logic [OW-1:0] hold;
        logic [OW-1:0] e;
        hold = '0;
        forever begin
            @(posedge clk);
            rst_s = rst;
            #1;
            if (rst_s) begin
                chk("rst_valid_out", 32'(valid_out), 32'd0);
                chk("rst_data_out", 32'(data_out), 32'd0);
                hold = '0;
            end else if (valid_out) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid_out", 32'(valid_out), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("data_out", 32'(data_out), 32'(e));
                    hold = e;
                end
            end else begin
                chk("hold_data_out", 32'(data_out), 32'(hold));
            end
        end
    end

    initial begin
        logic [63:0] t64;
        logic [31:0] t32;
        logic [IN_WIDTH-1:0] dat;
        logic [KW-1:0] w;
        logic signed [RW-1:0] nref;
        logic [PW-1:0] p;
        logic v;

        rst = 1'b1; valid_in = 1'b0; data_in = '0; weight_in = '0; norm_ref = '0; pindex = '0;
        drive(1'b1, 1'b0, '0, '0, '0, '0, '0);
        drive(1'b1, 1'b0, '0, '0, '0, '0, '0);
        idle(1);

        // all matching, full mask: S=36 everywhere
        drive(1'b0, 1'b1, '1, '1, 7'sd0, '1, 4'b1111);
        idle(1);
        // all mismatching: S=-36
        drive(1'b0, 1'b1, '1, '0, 7'sd0, '1, 4'b0000);
        drive(1'b0, 1'b1, '1, '0, -7'sd36, '1, 4'b1111);
        drive(1'b0, 1'b1, '1, '0, -7'sd35, '1, 4'b0000);
        // empty mask: S=0 regardless of data
        drive(1'b0, 1'b1, 64'hDEAD_BEEF_0123_4567, 36'h9_A5A5_C3C3, 7'sd0, '0, 4'b1111);
        drive(1'b0, 1'b1, 64'hDEAD_BEEF_0123_4567, 36'h9_A5A5_C3C3, 7'sd1, '0, 4'b0000);
        // single unmasked position only reaches pixel (0,0), S=4
        drive(1'b0, 1'b1, '1, '1, 7'sd1, 16'h0001, 4'b0001);
        drive(1'b0, 1'b1, '1, '1, 7'sd4, 16'h0001, 4'b0001);
        drive(1'b0, 1'b1, '1, '1, 7'sd5, 16'h0001, 4'b0000);
        // corner position 15 only reaches pixel (1,1)
        drive(1'b0, 1'b1, '1, '1, 7'sd1, 16'h8000, 4'b1000);
        // reset together with valid_in discards the window
        drive(1'b1, 1'b1, '1, '1, 7'sd0, '1, 4'b1111);
        drive(1'b0, 1'b1, '1, '1, 7'sd0, '1, 4'b1111);
        // single pulse then idle: output held
        drive(1'b0, 1'b1, '1, '1, 7'sd1, 16'h0001, 4'b0001);
        idle(4);

        for (int i = 0; i < 1000; i++) begin
            t64 = {$urandom, $urandom};
            dat = t64;
            t64 = {$urandom, $urandom};
            w = t64[KW-1:0];
            t32 = $urandom;
            p = (i % 8 == 0) ? '1 : t32[PW-1:0];
            nref = RW'($urandom_range(0, 40) - 20);
            v = ($urandom_range(0, 3) != 0);
            drive(1'b0, v, dat, w, nref, p, model(dat, w, nref, p));
        end
        idle(3);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
